// File: rtl/multicycle_control_fsm.sv
// Control unit for the RV32I multicycle datapath: sequences fetch, decode,
// execute, memory and write-back, and drives the datapath muxes and strobes.
module multicycle_control_fsm #(
   parameter int USE_MEM_READY   = 1,
   parameter int TRAP_ON_ILLEGAL = 1,
   parameter int STATE_WIDTH     = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [6:0]             opcode,
   input  logic [2:0]             funct3,
   input  logic [6:0]             funct7,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic                   MemoryAddressOrigin,
   output logic                   WriteMemory,
   output logic                   ReadMemory,
   output logic                   WriteInstructionRegister,
   output logic [1:0]             RegisterInputOrigin,
   output logic                   WriteRegister,
   output logic                   WriteCurrentPC,
   output logic [1:0]             ALUInputAOrigin,
   output logic [1:0]             ALUInputBOrigin,
   output logic [3:0]             ALUControl,
   output logic                   PCOrigin,
   output logic                   WritePC,
   output logic                   Illegal,
   output logic [STATE_WIDTH-1:0] StateOut
);

   typedef enum logic [STATE_WIDTH-1:0] {
      S_FETCH   = STATE_WIDTH'(4'd0),
      S_DECODE  = STATE_WIDTH'(4'd1),
      S_MEMADDR = STATE_WIDTH'(4'd2),
      S_LOAD    = STATE_WIDTH'(4'd3),
      S_LOADWB  = STATE_WIDTH'(4'd4),
      S_STORE   = STATE_WIDTH'(4'd5),
      S_EXEC_R  = STATE_WIDTH'(4'd6),
      S_EXEC_I  = STATE_WIDTH'(4'd7),
      S_ALUWB   = STATE_WIDTH'(4'd8),
      S_BRANCH  = STATE_WIDTH'(4'd9),
      S_JAL     = STATE_WIDTH'(4'd10),
      S_JALR    = STATE_WIDTH'(4'd11),
      S_LUI     = STATE_WIDTH'(4'd12),
      S_AUIPC   = STATE_WIDTH'(4'd13),
      S_TRAP    = STATE_WIDTH'(4'd15)
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   // Register-register and immediate ops share one mapping; only R-type honours SUB.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                             input logic is_reg);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_reg && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   state_t     state_r;
   state_t     state_next_s;
   logic       done_s;
   logic       trap_en_s;
   logic       mao_s, wm_s, rm_s, wir_s, wr_s, wcpc_s, pco_s, wpc_s, ill_s;
   logic [1:0] rio_s, a_s, b_s;
   logic [3:0] alu_s;

   assign done_s    = MemReady | (USE_MEM_READY == 0);
   assign trap_en_s = (TRAP_ON_ILLEGAL != 0);

   // State register with asynchronous reset to FETCH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      state_next_s = state_r;
      mao_s  = 1'b0;
      wm_s   = 1'b0;
      rm_s   = 1'b0;
      wir_s  = 1'b0;
      rio_s  = 2'd0;
      wr_s   = 1'b0;
      wcpc_s = 1'b0;
      a_s    = 2'd0;
      b_s    = 2'd0;
      alu_s  = ALU_ADD;
      pco_s  = 1'b0;
      wpc_s  = 1'b0;
      ill_s  = 1'b0;
      case (state_r)
         S_FETCH: begin
            rm_s = 1'b1;
            if (done_s) begin
               wir_s = 1'b1;
               wcpc_s = 1'b1;
               wpc_s = 1'b1;
               state_next_s = S_DECODE;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            a_s = 2'd2;
            b_s = 2'd2;
            case (opcode)
               OP_LOAD, OP_STORE: state_next_s = S_MEMADDR;
               OP_REG:            state_next_s = S_EXEC_R;
               OP_IMM:            state_next_s = S_EXEC_I;
               OP_BRANCH:         state_next_s = S_BRANCH;
               OP_JAL:            state_next_s = S_JAL;
               OP_JALR:           state_next_s = S_JALR;
               OP_LUI:            state_next_s = S_LUI;
               OP_AUIPC:          state_next_s = S_AUIPC;
               default:           state_next_s = trap_en_s ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEMADDR: begin
            a_s = 2'd1;
            b_s = 2'd2;
            if (opcode == OP_STORE) begin
               state_next_s = S_STORE;
            end else begin
               state_next_s = S_LOAD;
            end
         end
         S_LOAD: begin
            mao_s = 1'b1;
            rm_s = 1'b1;
            if (done_s) begin
               state_next_s = S_LOADWB;
            end else begin
               state_next_s = S_LOAD;
            end
         end
         S_LOADWB: begin
            rio_s = 2'd1;
            wr_s = 1'b1;
            state_next_s = S_FETCH;
         end
         S_STORE: begin
            mao_s = 1'b1;
            wm_s = 1'b1;
            if (done_s) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_STORE;
            end
         end
         S_EXEC_R: begin
            a_s = 2'd1;
            b_s = 2'd1;
            alu_s = alu_decode(funct3, funct7, 1'b1);
            state_next_s = S_ALUWB;
         end
         S_EXEC_I: begin
            a_s = 2'd1;
            b_s = 2'd2;
            alu_s = alu_decode(funct3, funct7, 1'b0);
            state_next_s = S_ALUWB;
         end
         S_ALUWB: begin
            wr_s = 1'b1;
            state_next_s = S_FETCH;
         end
         S_BRANCH: begin
            // Target was latched into ALUOut during DECODE; the ALU compares here.
            a_s = 2'd1;
            b_s = 2'd1;
            pco_s = 1'b1;
            state_next_s = S_FETCH;
            case (funct3)
               3'b000: begin alu_s = ALU_SUB;  wpc_s = Zero;  end
               3'b001: begin alu_s = ALU_SUB;  wpc_s = ~Zero; end
               3'b100: begin alu_s = ALU_SLT;  wpc_s = ~Zero; end
               3'b101: begin alu_s = ALU_SLT;  wpc_s = Zero;  end
               3'b110: begin alu_s = ALU_SLTU; wpc_s = ~Zero; end
               3'b111: begin alu_s = ALU_SLTU; wpc_s = Zero;  end
               default: state_next_s = trap_en_s ? S_TRAP : S_FETCH;
            endcase
         end
         S_JAL: begin
            rio_s = 2'd2;
            wr_s = 1'b1;
            pco_s = 1'b1;
            wpc_s = 1'b1;
            state_next_s = S_FETCH;
         end
         S_JALR: begin
            a_s = 2'd1;
            b_s = 2'd2;
            wpc_s = 1'b1;
            rio_s = 2'd2;
            wr_s = 1'b1;
            state_next_s = S_FETCH;
         end
         S_LUI: begin
            a_s = 2'd3;
            b_s = 2'd2;
            state_next_s = S_ALUWB;
         end
         S_AUIPC: begin
            a_s = 2'd2;
            b_s = 2'd2;
            state_next_s = S_ALUWB;
         end
         S_TRAP: begin
            ill_s = 1'b1;
            state_next_s = S_TRAP;
         end
         default: begin
            // Unused encodings behave exactly like FETCH.
            rm_s = 1'b1;
            if (done_s) begin
               wir_s = 1'b1;
               wcpc_s = 1'b1;
               wpc_s = 1'b1;
               state_next_s = S_DECODE;
            end else begin
               state_next_s = S_FETCH;
            end
         end
      endcase
   end

   // Strobes are squelched for as long as reset is held, aborting any access.
   assign WriteMemory              = wm_s & ~reset;
   assign ReadMemory               = rm_s & ~reset;
   assign WriteInstructionRegister = wir_s & ~reset;
   assign WriteRegister            = wr_s & ~reset;
   assign WriteCurrentPC           = wcpc_s & ~reset;
   assign WritePC                  = wpc_s & ~reset;
   assign MemoryAddressOrigin      = mao_s;
   assign RegisterInputOrigin      = rio_s;
   assign ALUInputAOrigin          = a_s;
   assign ALUInputBOrigin          = b_s;
   assign ALUControl               = alu_s;
   assign PCOrigin                 = pco_s;
   assign Illegal                  = ill_s;
   assign StateOut                 = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: a driver pushes hand-computed per-cycle output vectors,
// a monitor pops and compares them against two DUTs (trap on / trap off).
module tb_multicycle_control_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       mao, wm, rm, wir;
      logic [1:0] rio;
      logic       wr, wcpc;
      logic [1:0] a, b;
      logic [3:0] alu;
      logic       pco, wpc, ill;
   } obs_t;

   typedef struct {
      obs_t  e0;
      obs_t  e1;
      string tag;
   } item_t;

   function automatic obs_t mk(input logic [3:0] st, input logic mao, input logic wm,
                               input logic rm, input logic wir, input logic [1:0] rio,
                               input logic wr, input logic wcpc, input logic [1:0] a,
                               input logic [1:0] b, input logic [3:0] alu,
                               input logic pco, input logic wpc, input logic ill);
      obs_t o;
      o = {st, mao, wm, rm, wir, rio, wr, wcpc, a, b, alu, pco, wpc, ill};
      return o;
   endfunction

   //                       st    mao   wm    rm    wir   rio   wr    wcpc  a     b     alu   pco   wpc   ill
   localparam obs_t E_RST  = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_FD   = mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
   localparam obs_t E_FW   = mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_DEC  = mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_MA   = mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_LD   = mk(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_LWB  = mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_ST   = mk(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_ADD  = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_SUB  = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_AND  = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_ADDI = mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_SRAI = mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2, 4'd7, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_AWB  = mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_BT   = mk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 1'b1, 1'b1, 1'b0);
   localparam obs_t E_BN   = mk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0);
   localparam obs_t E_BLT  = mk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 4'd8, 1'b1, 1'b1, 1'b0);
   localparam obs_t E_JAL  = mk(4'd10,1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
   localparam obs_t E_JALR = mk(4'd11,1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b1, 1'b0);
   localparam obs_t E_LUI  = mk(4'd12,1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_AUI  = mk(4'd13,1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
   localparam obs_t E_TRAP = mk(4'd15,1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   logic       clock, reset, Zero, MemReady;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   logic       mao0, wm0, rm0, wir0, wr0, wcpc0, pco0, wpc0, ill0;
   logic [1:0] rio0, a0, b0;
   logic [3:0] alu0, st0;
   logic       mao1, wm1, rm1, wir1, wr1, wcpc1, pco1, wpc1, ill1;
   logic [1:0] rio1, a1, b1;
   logic [3:0] alu1, st1;

   obs_t o0, o1;
   assign o0 = {st0, mao0, wm0, rm0, wir0, rio0, wr0, wcpc0, a0, b0, alu0, pco0, wpc0, ill0};
   assign o1 = {st1, mao1, wm1, rm1, wir1, rio1, wr1, wcpc1, a1, b1, alu1, pco1, wpc1, ill1};

   multicycle_control_fsm #(.USE_MEM_READY(1), .TRAP_ON_ILLEGAL(1), .STATE_WIDTH(4)) dut_trap (
      .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .MemReady(MemReady),
      .MemoryAddressOrigin(mao0), .WriteMemory(wm0), .ReadMemory(rm0),
      .WriteInstructionRegister(wir0), .RegisterInputOrigin(rio0), .WriteRegister(wr0),
      .WriteCurrentPC(wcpc0), .ALUInputAOrigin(a0), .ALUInputBOrigin(b0),
      .ALUControl(alu0), .PCOrigin(pco0), .WritePC(wpc0), .Illegal(ill0), .StateOut(st0));

   multicycle_control_fsm #(.USE_MEM_READY(1), .TRAP_ON_ILLEGAL(0), .STATE_WIDTH(4)) dut_nop (
      .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .MemReady(MemReady),
      .MemoryAddressOrigin(mao1), .WriteMemory(wm1), .ReadMemory(rm1),
      .WriteInstructionRegister(wir1), .RegisterInputOrigin(rio1), .WriteRegister(wr1),
      .WriteCurrentPC(wcpc1), .ALUInputAOrigin(a1), .ALUInputBOrigin(b1),
      .ALUControl(alu1), .PCOrigin(pco1), .WritePC(wpc1), .Illegal(ill1), .StateOut(st1));

   item_t sb_q[$];
   int    checks = 0;
   int    errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: one expected vector per cycle, compared mid-cycle.
   initial begin
      item_t it;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (o0 !== it.e0) begin
               errors++;
               $display("FAIL %s trap_dut: got %h required %h", it.tag, o0, it.e0);
            end
            checks++;
            if (o1 !== it.e1) begin
               errors++;
               $display("FAIL %s nop_dut: got %h required %h", it.tag, o1, it.e1);
            end
         end
      end
   end

   task automatic run(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic mr,
                      input obs_t e0, input obs_t e1, input string tag);
      item_t it;
      @(posedge clock);
      #1;
      reset = r; opcode = opc; funct3 = f3; funct7 = f7; Zero = z; MemReady = mr;
      it.e0 = e0; it.e1 = e1; it.tag = tag;
      sb_q.push_back(it);
   endtask

   task automatic same(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic mr, input obs_t e, input string tag);
      run(1'b0, opc, f3, f7, z, mr, e, e, tag);
   endtask

   initial begin
      reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; MemReady = 1'b1;
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) run(1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1, E_RST, E_RST, "reset");

      // add then sub
      same(OP_REG, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,  "add_fetch");
      same(OP_REG, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC, "add_decode");
      same(OP_REG, 3'b000, 7'd0, 1'b0, 1'b1, E_ADD, "add_exec");
      same(OP_REG, 3'b000, 7'd0, 1'b0, 1'b1, E_AWB, "add_wb");
      same(OP_REG, 3'b000, F7_ALT, 1'b0, 1'b1, E_FD,  "sub_fetch");
      same(OP_REG, 3'b000, F7_ALT, 1'b0, 1'b1, E_DEC, "sub_decode");
      same(OP_REG, 3'b000, F7_ALT, 1'b0, 1'b1, E_SUB, "sub_exec");
      same(OP_REG, 3'b000, F7_ALT, 1'b0, 1'b1, E_AWB, "sub_wb");
      same(OP_REG, 3'b111, 7'd0, 1'b0, 1'b1, E_FD,  "and_fetch");
      same(OP_REG, 3'b111, 7'd0, 1'b0, 1'b1, E_DEC, "and_decode");
      same(OP_REG, 3'b111, 7'd0, 1'b0, 1'b1, E_AND, "and_exec");
      same(OP_REG, 3'b111, 7'd0, 1'b0, 1'b1, E_AWB, "and_wb");

      // lw with two wait states
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1, E_FD,  "lw_fetch");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1, E_DEC, "lw_decode");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1, E_MA,  "lw_memaddr");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b0, E_LD,  "lw_wait1");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b0, E_LD,  "lw_wait2");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1, E_LD,  "lw_done");
      same(OP_LOAD, 3'b010, 7'd0, 1'b0, 1'b1, E_LWB, "lw_wb");

      // sw with a fetch wait and a store wait
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0, E_FW,  "sw_fetch_wait");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_FD,  "sw_fetch");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_DEC, "sw_decode");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_MA,  "sw_memaddr");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0, E_ST,  "sw_wait");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_ST,  "sw_done");

      // branches
      same(OP_BRANCH, 3'b000, 7'd0, 1'b1, 1'b1, E_FD,  "beq_fetch");
      same(OP_BRANCH, 3'b000, 7'd0, 1'b1, 1'b1, E_DEC, "beq_decode");
      same(OP_BRANCH, 3'b000, 7'd0, 1'b1, 1'b1, E_BT,  "beq_taken");
      same(OP_BRANCH, 3'b001, 7'd0, 1'b1, 1'b1, E_FD,  "bne_fetch");
      same(OP_BRANCH, 3'b001, 7'd0, 1'b1, 1'b1, E_DEC, "bne_decode");
      same(OP_BRANCH, 3'b001, 7'd0, 1'b1, 1'b1, E_BN,  "bne_not_taken");
      same(OP_BRANCH, 3'b100, 7'd0, 1'b0, 1'b1, E_FD,  "blt_fetch");
      same(OP_BRANCH, 3'b100, 7'd0, 1'b0, 1'b1, E_DEC, "blt_decode");
      same(OP_BRANCH, 3'b100, 7'd0, 1'b0, 1'b1, E_BLT, "blt_taken");

      // immediates, upper immediates, jumps
      same(OP_IMM, 3'b000, F7_ALT, 1'b0, 1'b1, E_FD,   "addi_fetch");
      same(OP_IMM, 3'b000, F7_ALT, 1'b0, 1'b1, E_DEC,  "addi_decode");
      same(OP_IMM, 3'b000, F7_ALT, 1'b0, 1'b1, E_ADDI, "addi_exec");
      same(OP_IMM, 3'b000, F7_ALT, 1'b0, 1'b1, E_AWB,  "addi_wb");
      same(OP_IMM, 3'b101, F7_ALT, 1'b0, 1'b1, E_FD,   "srai_fetch");
      same(OP_IMM, 3'b101, F7_ALT, 1'b0, 1'b1, E_DEC,  "srai_decode");
      same(OP_IMM, 3'b101, F7_ALT, 1'b0, 1'b1, E_SRAI, "srai_exec");
      same(OP_IMM, 3'b101, F7_ALT, 1'b0, 1'b1, E_AWB,  "srai_wb");
      same(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,  "lui_fetch");
      same(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC, "lui_decode");
      same(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1, E_LUI, "lui_exec");
      same(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b1, E_AWB, "lui_wb");
      same(OP_AUIPC, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,  "auipc_fetch");
      same(OP_AUIPC, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC, "auipc_decode");
      same(OP_AUIPC, 3'b000, 7'd0, 1'b0, 1'b1, E_AUI, "auipc_exec");
      same(OP_AUIPC, 3'b000, 7'd0, 1'b0, 1'b1, E_AWB, "auipc_wb");
      same(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,   "jal_fetch");
      same(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC,  "jal_decode");
      same(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1, E_JAL,  "jal_exec");
      same(OP_JALR, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,   "jalr_fetch");
      same(OP_JALR, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC,  "jalr_decode");
      same(OP_JALR, 3'b000, 7'd0, 1'b0, 1'b1, E_JALR, "jalr_exec");

      // illegal opcode: trap instance parks in TRAP, nop instance keeps cycling
      same(OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, E_FD,  "bad_fetch");
      same(OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, E_DEC, "bad_decode");
      for (int i = 0; i < 20; i++)
         run(1'b0, OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, E_TRAP, (i % 2 == 0) ? E_FD : E_DEC, "bad_hold");
      run(1'b1, OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, E_RST, E_RST, "trap_reset");
      run(1'b1, OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, E_RST, E_RST, "trap_reset");

      // reset during a stalled store aborts it
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_FD,  "abort_fetch");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_DEC, "abort_decode");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_MA,  "abort_memaddr");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0, E_ST,  "abort_stall");
      run(1'b1, OP_STORE, 3'b010, 7'd0, 1'b0, 1'b0, E_RST, E_RST, "abort_reset");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_FD,  "abort_refetch");
      same(OP_STORE, 3'b010, 7'd0, 1'b0, 1'b1, E_DEC, "abort_redecode");

      @(negedge clock);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
